// File: rtl/hello_scroll_ctrl_if.sv
// Control/status bundle for the HELLO scroll controller: scroll controls in,
// rotation index and the six per-digit character codes out.
interface hello_scroll_ctrl_if;
  logic       en;
  logic       dir;
  logic       step;
  logic       load;
  logic [2:0] load_pos;
  logic [2:0] pos;
  logic [2:0] char5;
  logic [2:0] char4;
  logic [2:0] char3;
  logic [2:0] char2;
  logic [2:0] char1;
  logic [2:0] char0;
  logic       advanced;

  modport master (
    output en, dir, step, load, load_pos,
    input  pos, char5, char4, char3, char2, char1, char0, advanced
  );

  modport slave (
    input  en, dir, step, load, load_pos,
    output pos, char5, char4, char3, char2, char1, char0, advanced
  );
endinterface

// File: rtl/hello_scroll_ctrl.sv
// Timed/manual rotation of the message "HELLO " across HEX5..HEX0.
// The character codes are decoded combinationally from the position register.
module hello_scroll_ctrl #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned CNT_W    = 25
) (
  input logic              CLOCK_50,
  input logic              Reset,
  hello_scroll_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CH_H     = 3'b000,
    CH_E     = 3'b001,
    CH_L     = 3'b010,
    CH_O     = 3'b011,
    CH_BLANK = 3'b100
  } char_t;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       pos;
  logic [2:0]       pos_next;
  logic             step_d;
  logic             advanced;
  logic             tick;
  logic             step_edge;
  logic             adv_req;
  logic [2:0]       ch [6];

  function automatic char_t msg_code(input int unsigned idx);
    case (idx)
      0:       return CH_H;
      1:       return CH_E;
      2, 3:    return CH_L;
      4:       return CH_O;
      default: return CH_BLANK;
    endcase
  endfunction

  assign tick      = bus.en && (cnt == CNT_W'(TICK_DIV - 1));
  assign step_edge = bus.step && !step_d;
  assign adv_req   = tick || step_edge;

  always_comb begin
    pos_next = pos;
    if (bus.dir) pos_next = (pos == 3'd0) ? 3'd5 : pos - 3'd1;
    else         pos_next = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      pos      <= '0;
      cnt      <= '0;
      step_d   <= 1'b0;
      advanced <= 1'b0;
    end else begin
      step_d   <= bus.step;
      advanced <= 1'b0;
      if (bus.load) begin
        pos <= (bus.load_pos <= 3'd5) ? bus.load_pos : 3'd0;
        cnt <= '0;
      end else begin
        // A manual step restarts the full interval; a tick wraps to the same value.
        if (step_edge || tick) cnt <= '0;
        else if (bus.en)       cnt <= cnt + CNT_W'(1);
        if (adv_req) begin
          pos      <= pos_next;
          advanced <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 6; k++) begin
      ch[k] = msg_code((32'(pos) + 32'd5 - k) % 32'd6);
    end
  end

  assign bus.pos      = pos;
  assign bus.advanced = advanced;
  assign bus.char5    = ch[5];
  assign bus.char4    = ch[4];
  assign bus.char3    = ch[3];
  assign bus.char2    = ch[2];
  assign bus.char1    = ch[1];
  assign bus.char0    = ch[0];

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Bench for hello_scroll_ctrl with TICK_DIV=4: vector table plus hand sequences,
// expectations queued at drive time and popped after each clock edge.
module tb_hello_scroll_ctrl;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       step;
    logic       load;
    logic [2:0] lpos;
    logic [2:0] pos;
    logic       adv;
  } vec_t;

  typedef struct {
    logic [2:0] pos;
    logic       adv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  vec_t tbl[$];
  exp_t sb[$];
  logic [17:0] chars_by_pos [6];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  hello_scroll_ctrl_if bus();

  hello_scroll_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
    .CLOCK_50(clk),
    .Reset   (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, e, d, s, l, input logic [2:0] lp, p, input logic a);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.step = s; v.load = l;
    v.lpos = lp; v.pos = p; v.adv = a;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic run_row(input vec_t v, input int idx);
    exp_t e;
    logic [17:0] chars;
    rst          = v.rst;
    bus.en       = v.en;
    bus.dir      = v.dir;
    bus.step     = v.step;
    bus.load     = v.load;
    bus.load_pos = v.lpos;
    e.pos = v.pos;
    e.adv = v.adv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard_empty row %0d: actual=0 required=1", idx);
    end else begin
      e = sb.pop_front();
      chars = {bus.char5, bus.char4, bus.char3, bus.char2, bus.char1, bus.char0};
      check($sformatf("pos[%0d]", idx), 32'(bus.pos), 32'(e.pos));
      check($sformatf("advanced[%0d]", idx), 32'(bus.advanced), 32'(e.adv));
      check($sformatf("chars[%0d]", idx), 32'(chars), 32'(chars_by_pos[e.pos]));
    end
  endtask

  task automatic row(input logic r, e, d, s, l, input logic [2:0] lp, p, input logic a, input int idx);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.step = s; v.load = l;
    v.lpos = lp; v.pos = p; v.adv = a;
    run_row(v, idx);
  endtask

  initial begin
    chars_by_pos[0] = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
    chars_by_pos[1] = {3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd0};
    chars_by_pos[2] = {3'd2, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    chars_by_pos[3] = {3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
    chars_by_pos[4] = {3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd2};
    chars_by_pos[5] = {3'd4, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3};

    rst = 1'b1; bus.en = 1'b0; bus.dir = 1'b0; bus.step = 1'b0;
    bus.load = 1'b0; bus.load_pos = 3'd0;

    // Reset then 24 auto-scroll cycles: an advance on every 4th clock, wrapping 5->0.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 24; n++)
      add(0, 1, 0, 0, 0, 0, 3'((n / 4) % 6), (n % 4) == 0);
    // Scroll right from pos 0 wraps to 5.
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 5, 1);
    // Held step with en=0: one advance, then a second edge gives another.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1);
    for (int n = 0; n < 9; n++) add(0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0);
    // Step edge coinciding with the tick (cnt==3): single advance.
    add(0, 1, 0, 0, 0, 0, 2, 0);
    add(0, 1, 0, 0, 0, 0, 2, 0);
    add(0, 1, 0, 0, 0, 0, 2, 0);
    add(0, 1, 0, 1, 0, 0, 3, 1);
    add(0, 1, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 1, 0, 0, 4, 1);
    // Step edge at cnt==1 clears the prescaler: next tick a full 4 cycles later.
    add(0, 1, 0, 0, 0, 0, 4, 0);
    add(0, 1, 0, 1, 0, 0, 5, 1);
    add(0, 1, 0, 1, 0, 0, 5, 0);
    add(0, 1, 0, 1, 0, 0, 5, 0);
    add(0, 1, 0, 1, 0, 0, 5, 0);
    add(0, 1, 0, 1, 0, 0, 0, 1);
    // Load on a tick cycle wins and suppresses advanced; out-of-range loads give 0.
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3, 3, 0);
    add(0, 1, 0, 0, 0, 0, 3, 0);
    add(0, 1, 0, 0, 1, 6, 0, 0);
    add(0, 1, 0, 0, 1, 5, 5, 0);
    add(0, 1, 0, 1, 1, 2, 2, 0);
    add(0, 1, 0, 1, 0, 0, 2, 0);
    add(0, 1, 0, 0, 1, 7, 0, 0);

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    // Reset mid-scroll at pos=4, cnt=2; first auto-advance 4 clocks after release.
    row(0, 1, 0, 0, 1, 4, 4, 0, 100);
    row(0, 1, 0, 0, 0, 0, 4, 0, 101);
    row(0, 1, 0, 0, 0, 0, 4, 0, 102);
    row(1, 1, 0, 0, 0, 0, 0, 0, 103);
    row(0, 1, 0, 0, 0, 0, 0, 0, 104);
    row(0, 1, 0, 0, 0, 0, 0, 0, 105);
    row(0, 1, 0, 0, 0, 0, 0, 0, 106);
    row(0, 1, 0, 0, 0, 0, 1, 1, 107);

    // Reset on a tick cycle: no advance that cycle.
    row(0, 1, 0, 0, 1, 4, 4, 0, 110);
    row(0, 1, 0, 0, 0, 0, 4, 0, 111);
    row(0, 1, 0, 0, 0, 0, 4, 0, 112);
    row(0, 1, 0, 0, 0, 0, 4, 0, 113);
    row(1, 1, 0, 1, 0, 0, 0, 0, 114);

    // en=0 freezes the prescaler mid-count.
    row(0, 1, 0, 0, 0, 0, 0, 0, 120);
    row(0, 1, 0, 0, 0, 0, 0, 0, 121);
    for (int n = 0; n < 5; n++) row(0, 0, 0, 0, 0, 0, 0, 0, 122 + n);
    row(0, 1, 0, 0, 0, 0, 0, 0, 127);
    row(0, 1, 0, 0, 0, 0, 1, 1, 128);
    row(0, 1, 0, 0, 0, 0, 1, 0, 129);

    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
